// File: rtl/sift_pkg.sv
// Shared SIFT pipeline types, constants and helpers.
// Used by the gradient stage and reused by the descriptor stage.
package sift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } gradient_state_t;

    localparam int unsigned BRAM_READ_LATENCY = 2;
    localparam int unsigned GRAD_PHASES       = 6;

    // Replicated-border clamp of a neighbour coordinate into [0, size-1].
    function automatic int clamp_coord(input int c, input int unsigned size);
        if (c < 0) begin
            return 0;
        end
        if (c > int'(size) - 1) begin
            return int'(size) - 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/gradient_level.sv
// Central-difference x/y gradients for one Gaussian-pyramid level.
// Sequential: four BRAM reads and one gradient write per pixel, raster order.
module gradient_level
    import sift_pkg::*;
#(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned HEIGHT        = 64,
    parameter int unsigned IMG_BIT_DEPTH = 8,
    parameter int unsigned BIT_DEPTH     = IMG_BIT_DEPTH + 1,
    localparam int unsigned ADDR_W       = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    output logic [ADDR_W-1:0]           img_addr,
    input  logic [IMG_BIT_DEPTH-1:0]    img_data,
    output logic [ADDR_W-1:0]           grad_addr,
    output logic signed [BIT_DEPTH-1:0] grad_x_out,
    output logic signed [BIT_DEPTH-1:0] grad_y_out,
    output logic                        grad_wea,
    output logic                        busy,
    output logic                        gradients_done
);

    localparam int unsigned XW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW          = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned PHASE_W     = $clog2(GRAD_PHASES);
    localparam int unsigned ADDR_PHASES = 4;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(GRAD_PHASES - 1);
    localparam logic [PHASE_W-1:0] CAP_L      = PHASE_W'(BRAM_READ_LATENCY);
    localparam logic [PHASE_W-1:0] CAP_R      = PHASE_W'(BRAM_READ_LATENCY + 1);
    localparam logic [PHASE_W-1:0] CAP_U      = PHASE_W'(BRAM_READ_LATENCY + 2);

    gradient_state_t state, state_n;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [IMG_BIT_DEPTH-1:0] pix_l, pix_r, pix_u;
    int nb_x, nb_y;
    logic [ADDR_W-1:0] nb_addr;

    // Next-state and raster advance.
    always_comb begin
        state_n = state;
        phase_n = phase;
        x_n     = x;
        y_n     = y;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = READ;
                    phase_n = '0;
                    x_n     = '0;
                    y_n     = '0;
                end
            end
            READ: begin
                if (phase == LAST_PHASE) begin
                    state_n = WRITE;
                end else begin
                    phase_n = phase + PHASE_W'(1);
                end
            end
            WRITE: begin
                phase_n = '0;
                if (x == XW'(WIDTH - 1)) begin
                    x_n = '0;
                    if (y == YW'(HEIGHT - 1)) begin
                        state_n = DONE;
                    end else begin
                        y_n     = y + YW'(1);
                        state_n = READ;
                    end
                end else begin
                    x_n     = x + XW'(1);
                    state_n = READ;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Neighbour address for the phase about to run: left, right, up, down.
    always_comb begin
        nb_x = int'(x_n);
        nb_y = int'(y_n);
        if (phase_n == PHASE_W'(0)) begin
            nb_x = clamp_coord(int'(x_n) - 1, WIDTH);
        end else if (phase_n == PHASE_W'(1)) begin
            nb_x = clamp_coord(int'(x_n) + 1, WIDTH);
        end else if (phase_n == PHASE_W'(2)) begin
            nb_y = clamp_coord(int'(y_n) - 1, HEIGHT);
        end else begin
            nb_y = clamp_coord(int'(y_n) + 1, HEIGHT);
        end
        nb_addr = ADDR_W'(nb_y * int'(WIDTH) + nb_x);
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            phase          <= '0;
            x              <= '0;
            y              <= '0;
            pix_l          <= '0;
            pix_r          <= '0;
            pix_u          <= '0;
            img_addr       <= '0;
            grad_addr      <= '0;
            grad_x_out     <= '0;
            grad_y_out     <= '0;
            grad_wea       <= 1'b0;
            busy           <= 1'b0;
            gradients_done <= 1'b0;
        end else begin
            state          <= state_n;
            phase          <= phase_n;
            x              <= x_n;
            y              <= y_n;
            busy           <= (state_n == READ) || (state_n == WRITE);
            grad_wea       <= (state_n == WRITE);
            gradients_done <= (state_n == DONE);
            if (state_n == READ && phase_n < PHASE_W'(ADDR_PHASES)) begin
                img_addr <= nb_addr;
            end
            // Data returns BRAM_READ_LATENCY phases after its address; the down
            // sample is consumed directly as it arrives in the last phase.
            if (state == READ) begin
                if (phase == CAP_L) pix_l <= img_data;
                if (phase == CAP_R) pix_r <= img_data;
                if (phase == CAP_U) pix_u <= img_data;
                if (phase == LAST_PHASE) begin
                    grad_x_out <= BIT_DEPTH'(pix_r) - BIT_DEPTH'(pix_l);
                    grad_y_out <= BIT_DEPTH'(img_data) - BIT_DEPTH'(pix_u);
                    grad_addr  <= ADDR_W'(int'(y) * int'(WIDTH) + int'(x));
                end
            end
        end
    end

endmodule

// File: tb/tb_gradient_level.sv
// Self-checking bench for gradient_level on a 4x4 level with a 2-cycle BRAM model.
// Expected gradients, addresses and timing come from a plain-arithmetic image model.
module tb_gradient_level;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 4;
    localparam int IB = 8;
    localparam int BD = 9;

    logic clk = 1'b0;
    logic rst_in;
    logic start;
    logic [AW-1:0] img_addr;
    logic [AW-1:0] grad_addr;
    logic [IB-1:0] img_data;
    logic [IB-1:0] rd_p1;
    logic signed [BD-1:0] grad_x_out;
    logic signed [BD-1:0] grad_y_out;
    logic grad_wea;
    logic busy;
    logic gradients_done;

    typedef struct {
        int addr;
        int gx;
        int gy;
        int c;
    } wr_t;

    int  mem [N];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t wq[$];
    wr_t first_wq[$];
    int  dq[$];
    int  addr_tr[int];
    int  busy_tr[int];

    gradient_level #(
        .WIDTH(W),
        .HEIGHT(H),
        .IMG_BIT_DEPTH(IB)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .start(start),
        .img_addr(img_addr),
        .img_data(img_data),
        .grad_addr(grad_addr),
        .grad_x_out(grad_x_out),
        .grad_y_out(grad_y_out),
        .grad_wea(grad_wea),
        .busy(busy),
        .gradients_done(gradients_done)
    );

    always #5 clk = ~clk;

    // Cycle counter and two-cycle-latency BRAM.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_p1   <= IB'(mem[img_addr]);
        img_data <= rd_p1;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t w;
        addr_tr[cyc] = int'(img_addr);
        busy_tr[cyc] = int'(busy);
        if (grad_wea) begin
            w.addr = int'(grad_addr);
            w.gx   = int'(grad_x_out);
            w.gy   = int'(grad_y_out);
            w.c    = cyc;
            wq.push_back(w);
        end
        if (gradients_done) dq.push_back(cyc);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cl(input int v, input int n);
        return (v < 0) ? 0 : ((v > n - 1) ? n - 1 : v);
    endfunction

    function automatic int pix(input int px, input int py);
        return mem[py * W + px];
    endfunction

    function automatic int exp_rd(input int px, input int py, input int p);
        case (p)
            0:       return py * W + cl(px - 1, W);
            1:       return py * W + cl(px + 1, W);
            2:       return cl(py - 1, H) * W + px;
            default: return cl(py + 1, H) * W + px;
        endcase
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " img_addr"}, int'(img_addr), 0);
        chk({tag, " grad_addr"}, int'(grad_addr), 0);
        chk({tag, " grad_x"}, int'(grad_x_out), 0);
        chk({tag, " grad_y"}, int'(grad_y_out), 0);
        chk({tag, " grad_wea"}, int'(grad_wea), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(gradients_done), 0);
    endtask

    task automatic clear_logs();
        wq.delete();
        dq.delete();
    endtask

    task automatic start_frame(output int base);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = cyc - 1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dq.size() == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, " done seen"}, int'(dq.size() > 0), 1);
    endtask

    task automatic check_frame(input string tag, input int base);
        chk({tag, " write count"}, wq.size(), N);
        for (int k = 0; k < N; k++) begin
            int px = k % W;
            int py = k / W;
            if (k < wq.size()) begin
                chk($sformatf("%s px%0d addr", tag, k), wq[k].addr, k);
                chk($sformatf("%s px%0d gx", tag, k), wq[k].gx,
                    pix(cl(px + 1, W), py) - pix(cl(px - 1, W), py));
                chk($sformatf("%s px%0d gy", tag, k), wq[k].gy,
                    pix(px, cl(py + 1, H)) - pix(px, cl(py - 1, H)));
                chk($sformatf("%s px%0d write cycle", tag, k), wq[k].c - base, 7 * k + 7);
            end
            for (int p = 0; p < 4; p++) begin
                int c = base + 7 * k + 1 + p;
                chk($sformatf("%s px%0d rd%0d", tag, k, p),
                    addr_tr.exists(c) ? addr_tr[c] : -1, exp_rd(px, py, p));
            end
        end
        chk({tag, " done count"}, dq.size(), 1);
        if (dq.size() > 0) chk({tag, " done cycle"}, dq[0] - base, 7 * N + 1);
        chk({tag, " busy first"}, busy_tr.exists(base + 1) ? busy_tr[base + 1] : -1, 1);
        chk({tag, " busy last write"}, busy_tr.exists(base + 7 * N) ? busy_tr[base + 7 * N] : -1, 1);
        chk({tag, " busy at done"}, busy_tr.exists(base + 7 * N + 1) ? busy_tr[base + 7 * N + 1] : -1, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = int'($urandom_range(255));
    endtask

    initial begin
        int b;
        rst_in = 1'b1;
        start  = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_in = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp image I(x,y) = 16x + y.
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) mem[yy * W + xx] = 16 * xx + yy;
        clear_logs();
        start_frame(b);
        wait_done("ramp");
        check_frame("ramp", b);
        if (wq.size() == N) begin
            chk("ramp corner gx", wq[0].gx, 16);
            chk("ramp corner gy", wq[0].gy, 1);
            chk("ramp interior gx", wq[5].gx, 32);
            chk("ramp interior gy", wq[5].gy, 2);
            chk("ramp last gx", wq[15].gx, 16);
            chk("ramp last gy", wq[15].gy, 1);
        end
        chk("ramp px0 rd3", addr_tr[b + 4], 4);
        chk("ramp px15 rd2", addr_tr[b + 7 * 15 + 3], 11);
        first_wq = wq;

        // Back-to-back: start in the idle cycle right after the done pulse.
        clear_logs();
        start_frame(b);
        wait_done("b2b");
        check_frame("b2b", b);
        for (int k = 0; k < N; k++) begin
            if (k < wq.size() && k < first_wq.size()) begin
                chk($sformatf("b2b same gx px%0d", k), wq[k].gx, first_wq[k].gx);
                chk($sformatf("b2b same gy px%0d", k), wq[k].gy, first_wq[k].gy);
            end
        end

        // Random image with start re-pulsed while busy.
        fill_random();
        clear_logs();
        start_frame(b);
        while (cyc - b < 20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse");
        repeat (30) @(negedge clk);
        check_frame("repulse", b);
        chk("repulse idle busy", int'(busy), 0);

        // Extremes: column 1 at full scale, everything else zero.
        for (int i = 0; i < N; i++) mem[i] = ((i % W) == 1) ? 255 : 0;
        clear_logs();
        start_frame(b);
        wait_done("extreme");
        check_frame("extreme", b);
        if (wq.size() == N) begin
            chk("extreme gx x0", wq[4].gx, 255);
            chk("extreme gx x1", wq[5].gx, 0);
            chk("extreme gx x2", wq[6].gx, -255);
            chk("extreme gy x1", wq[5].gy, 0);
        end

        // Asynchronous reset during pixel 5's read, then a fresh frame.
        fill_random();
        clear_logs();
        start_frame(b);
        while (cyc - b < 38) @(negedge clk);
        #1 rst_in = 1'b1;
        #1 chk_outputs_zero("midreset");
        @(negedge clk);
        rst_in = 1'b0;
        clear_logs();
        repeat (120) @(negedge clk);
        chk("midreset no writes", wq.size(), 0);
        chk("midreset no done", dq.size(), 0);
        fill_random();
        clear_logs();
        start_frame(b);
        wait_done("after reset");
        check_frame("after reset", b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
